// File: rtl/quad_window_counter_if.sv
// Encoder pins, window strobes and captured-result bus of quad_window_counter.
interface quad_window_counter_if #(
    parameter int WIDTH = 16
);
    logic                    enc_a;
    logic                    enc_b;
    logic                    load_in;
    logic                    clear_in;
    logic signed [WIDTH-1:0] count_out;
    logic                    count_valid;
    logic                    sat_out;
    logic                    err_out;

    modport master (
        output enc_a, enc_b, load_in, clear_in,
        input  count_out, count_valid, sat_out, err_out
    );

    modport slave (
        input  enc_a, enc_b, load_in, clear_in,
        output count_out, count_valid, sat_out, err_out
    );
endinterface

// File: rtl/quad_window_counter.sv
// Quadrature window counter: sync/filter, Gray decode, saturating window accumulator, load capture.
// Optional glitch filter on each phase is compiled in with `define ENC_FILTER_EN.
module qwc_phase_in #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level
);
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[0], pin};
    end

`ifdef ENC_FILTER_EN
    // A new level must differ from the accepted one for FILTER_LEN straight cycles.
    logic [3:0] cnt;
    logic       flt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            flt <= 1'b0;
        end else if (sync[1] == flt) begin
            cnt <= '0;
        end else if (cnt == 4'(FILTER_LEN - 1)) begin
            flt <= sync[1];
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    assign level = flt;
`else
    assign level = sync[1];
`endif
endmodule

module quad_window_counter #(
    parameter int WIDTH      = 16,
    parameter int FILTER_LEN = 4
) (
    input logic                  clk,
    input logic                  reset,
    quad_window_counter_if.slave bus
);
    localparam logic signed [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [WIDTH-1:0] NEG_ONE = '1;

    logic [1:0]              pins;
    logic [1:0]              cur;
    logic [1:0]              prev;
    logic                    up;
    logic                    dn;
    logic                    illegal;
    logic                    sat_evt;
    logic signed [WIDTH-1:0] step_val;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] acc_step;
    logic                    sat_flag;
    logic                    err_flag;
    logic signed [WIDTH-1:0] count_q;
    logic                    valid_q;
    logic                    sat_q;
    logic                    err_q;

    // Bit 1 carries phase A, bit 0 phase B.
    assign pins = {bus.enc_a, bus.enc_b};

    qwc_phase_in #(.FILTER_LEN(FILTER_LEN)) u_phase [1:0] (
        .clk   (clk),
        .reset (reset),
        .pin   (pins),
        .level (cur)
    );

    always_comb begin
        up      = 1'b0;
        dn      = 1'b0;
        illegal = 1'b0;
        case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: up      = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: dn      = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        step_val = '0;
        if (up) step_val = ONE;
        if (dn) step_val = NEG_ONE;
    end

    // A step that would wrap is dropped and recorded as saturation instead.
    assign sat_evt  = (up && acc == ACC_MAX) || (dn && acc == ACC_MIN);
    assign acc_step = sat_evt ? acc : acc + step_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= 2'b00;
            acc      <= '0;
            sat_flag <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            prev <= cur;
            if (bus.clear_in) begin
                acc      <= step_val;
                sat_flag <= sat_evt;
                err_flag <= illegal;
            end else begin
                acc      <= acc_step;
                sat_flag <= sat_flag | sat_evt;
                err_flag <= err_flag | illegal;
            end
        end
    end

    // Capture uses the pre-update window so load+clear reports the closing window.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= bus.load_in;
            if (bus.load_in) begin
                count_q <= acc;
                sat_q   <= sat_flag;
                err_q   <= err_flag;
            end
        end
    end

    assign bus.count_out   = count_q;
    assign bus.count_valid = valid_q;
    assign bus.sat_out     = sat_q;
    assign bus.err_out     = err_q;
endmodule

// File: doc/quad_window_counter.md
# quad_window_counter

Quadrature encoder window counter: the consumer of the periodic load/clear strobe pair produced by the window timer. It decodes the two-phase encoder inputs into a signed up/down step count, accumulates steps over one timer window, and captures the window result into a held output register on each load strobe. It then restarts accumulation on the following clear strobe. It sits between the encoder pins and the speed/position display logic.

## Interface
- `WIDTH`, 16: bit width of the signed accumulator and `count_out`.
- `FILTER_LEN`, 4: stable cycles required before a filtered input change is accepted (used only with the filter compiled in; legal range 2–15).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enc_a`  in  1  encoder phase A, asynchronous to `clk`.
- `enc_b`  in  1  encoder phase B, asynchronous to `clk`.
- `load_in`  in  1  one-cycle strobe: capture window result.
- `clear_in`  in  1  one-cycle strobe: restart accumulation.
- `count_out`  out  WIDTH  signed two's-complement step count of the last captured window.
- `count_valid`  out  1  one-cycle pulse; `count_out` was updated this cycle.
- `sat_out`  out  1  the captured window saturated.
- `err_out`  out  1  the captured window contained at least one illegal transition.

## Operation
- Input path: each of `enc_a` and `enc_b` passes through a 2-flop synchronizer, optionally followed by the filter. The result is the accepted state `{a,b}`, registered as `prev`.
- Decode: Gray sequence 00→01→11→10→00 gives step +1, the reverse gives −1, and no change gives 0.
- Illegal transition: both bits change in one cycle. The step is 0 and the window error flag is set.
- Accumulator `acc` (signed WIDTH):
  - `acc <= acc + step`.
  - At +2^(WIDTH−1)−1 a +1 step holds the value and sets the window saturation flag. At −2^(WIDTH−1) a −1 step is handled the same way.
- Load (`load_in`=1):
  - `count_out <= acc` (the value before this cycle's step). `sat_out` and `err_out` take the window flags as they stand before this cycle's events.
  - `count_valid` is 1 in the following cycle.
  - The step in the load cycle is still added to `acc`.
- Clear (`clear_in`=1):
  - `acc <= step` (−1/0/+1), so no edge is lost.
  - The window flags are reset to the current cycle's illegal/saturation status.
- Load and clear in the same cycle: the load captures the pre-clear values, then the clear applies. Both take effect.
- Outputs are unaffected by clear; they change only on load.

## Timing
- Reset values: `count_out`=0, `count_valid`=0, `sat_out`=0, `err_out`=0, `acc`=0, flags=0. The synchronizers and `prev` load the current synchronized pin levels' reset image 00, and the first post-reset cycles decode from 00.
- Reset takes priority over load and clear in the same cycle.
- Pin-to-`acc` latency: 3 cycles without the filter (2 sync + 1 decode/accumulate), and 3+FILTER_LEN cycles with it.
- `load_in` to `count_out`/`count_valid`/`sat_out`/`err_out`: 1 cycle.
- Maximum trackable edge rate: one accepted state change per cycle.

## Configuration
- `ENC_FILTER_EN`
  - Defined: each synchronized phase has a per-phase counter. A new level is accepted only after it has been stable for FILTER_LEN consecutive cycles, and shorter glitches are dropped.
  - Undefined: the synchronizer output feeds decode directly, and `FILTER_LEN` is ignored.

## Test plan
- Reset, then 10 forward quadrature cycles (40 edges, 8 clk per edge), then load → `count_out`=40, `count_valid` for 1 cycle, `sat_out`=0, `err_out`=0.
- Clear, then 25 reverse edges, then load → `count_out`=−25. Load again with no clear and 5 forward edges → `count_out`=−20.
- WIDTH=8, 130 forward edges in one window → `count_out`=127, `sat_out`=1. After clear + load with no edges → `count_out`=0, `sat_out`=0.
- Force `{enc_a,enc_b}` 00→11 in one clk → no count change. Next load gives `err_out`=1; the load after a clear gives `err_out`=0.
- A step arriving in the same cycle as `clear_in` → `acc`=±1 afterwards. `load_in`+`clear_in` together with `acc`=7 → `count_out`=7, `acc` restarts.
- `ENC_FILTER_EN`, FILTER_LEN=4: a 3-cycle glitch on `enc_a` gives no count, while a 5-cycle-stable edge gives +1 at latency 7 cycles. Without the macro, the same glitch produces a +1/−1 pair, net 0.
